// File: rtl/chacha20_pkg.sv
// rtl/chacha20_pkg.sv - shared widths and controller state encoding
package chacha20_pkg;

    localparam int CHACHA_KEY_W   = 256;
    localparam int CHACHA_NONCE_W = 96;
    localparam int CHACHA_CTR_W   = 32;
    localparam int CHACHA_BLOCK_W = 512;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_CORE = 3'd2,
        GAP       = 3'd3,
        DRAIN     = 3'd4
    } state_e;

endpackage

// File: rtl/chacha20_out_buf.sv
// rtl/chacha20_out_buf.sv - one-entry keystream output register with valid/ready
module chacha20_out_buf
    import chacha20_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [CHACHA_BLOCK_W-1:0] load_data,
    input  logic [CHACHA_CTR_W-1:0]   load_counter,
    input  logic                      load_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHACHA_BLOCK_W-1:0] out_data,
    output logic [CHACHA_CTR_W-1:0]   out_counter,
    output logic                      out_last
);

    logic                      valid_q, valid_d;
    logic [CHACHA_BLOCK_W-1:0] data_q, data_d;
    logic [CHACHA_CTR_W-1:0]   counter_q, counter_d;
    logic                      last_q, last_d;

    // Fill on load, empty on handshake; payload only changes on load so it holds while stalled
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        counter_d = counter_q;
        last_d    = last_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (load) begin
            valid_d   = 1'b1;
            data_d    = load_data;
            counter_d = load_counter;
            last_d    = load_last;
        end
    end

    // Register update with synchronous reset clearing the entry
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            counter_q <= '0;
            last_q    <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            counter_q <= counter_d;
            last_q    <= last_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_counter = counter_q;
    assign out_last    = last_q;

endmodule

// File: rtl/chacha20_stream_ctrl.sv
// rtl/chacha20_stream_ctrl.sv - sequences a ChaCha20 core over a multi-block keystream job
module chacha20_stream_ctrl
    import chacha20_pkg::*;
#(
    parameter int MAX_BLOCKS_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CHACHA_KEY_W-1:0]   cmd_key,
    input  logic [CHACHA_NONCE_W-1:0] cmd_nonce,
    input  logic [CHACHA_CTR_W-1:0]   cmd_counter,
    input  logic [MAX_BLOCKS_W-1:0]   cmd_nblocks,
    output logic                      core_start,
    output logic [CHACHA_KEY_W-1:0]   core_key,
    output logic [CHACHA_NONCE_W-1:0] core_nonce,
    output logic [CHACHA_CTR_W-1:0]   core_counter,
    input  logic [CHACHA_BLOCK_W-1:0] core_keystream,
    input  logic                      core_done,
    output logic                      ks_valid,
    input  logic                      ks_ready,
    output logic [CHACHA_BLOCK_W-1:0] ks_data,
    output logic [CHACHA_CTR_W-1:0]   ks_counter,
    output logic                      ks_last,
    output logic                      busy,
    output logic                      job_done,
    output logic                      err_wrap
);

    state_e                    state_q, state_d;
    logic [CHACHA_KEY_W-1:0]   key_q, key_d;
    logic [CHACHA_NONCE_W-1:0] nonce_q, nonce_d;
    logic [CHACHA_CTR_W-1:0]   counter_q, counter_d;
    logic [MAX_BLOCKS_W-1:0]   remaining_q, remaining_d;
    logic                      core_start_q, core_start_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      busy_q, busy_d;
    logic                      job_done_q, job_done_d;
    logic                      err_wrap_q, err_wrap_d;
    logic                      buf_load;

    // Blocks left before the counter passes 0xFFFFFFFF; a longer request is truncated to this
    logic [CHACHA_CTR_W:0]     room;
    logic [CHACHA_CTR_W:0]     nblocks_ext;
    logic                      wrap;

    assign room        = {1'b1, {CHACHA_CTR_W{1'b0}}} - {1'b0, cmd_counter};
    assign nblocks_ext = {{(CHACHA_CTR_W + 1 - MAX_BLOCKS_W){1'b0}}, cmd_nblocks};
    assign wrap        = nblocks_ext > room;

    // Next-state and job bookkeeping; core_done only matters while waiting on the core
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        nonce_d     = nonce_q;
        counter_d   = counter_q;
        remaining_d = remaining_q;
        job_done_d  = 1'b0;
        err_wrap_d  = 1'b0;
        buf_load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    key_d     = cmd_key;
                    nonce_d   = cmd_nonce;
                    counter_d = cmd_counter;
                    if (cmd_nblocks == '0) begin
                        job_done_d = 1'b1;
                    end else begin
                        remaining_d = wrap ? room[MAX_BLOCKS_W-1:0] : cmd_nblocks;
                        err_wrap_d  = wrap;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT_CORE;
            WAIT_CORE: begin
                if (core_done) begin
                    buf_load = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: state_d = DRAIN;
            DRAIN: begin
                // An empty buffer here means the block was already taken during GAP
                if (!ks_valid || ks_ready) begin
                    if (remaining_q > 1) begin
                        remaining_d = remaining_q - 1'b1;
                        counter_d   = counter_q + 1'b1;
                        state_d     = ISSUE;
                    end else begin
                        remaining_d = '0;
                        job_done_d  = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        core_start_d = (state_d == ISSUE) || (state_d == WAIT_CORE);
        cmd_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any job in flight without a job_done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            key_q        <= '0;
            nonce_q      <= '0;
            counter_q    <= '0;
            remaining_q  <= '0;
            core_start_q <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            job_done_q   <= 1'b0;
            err_wrap_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            counter_q    <= counter_d;
            remaining_q  <= remaining_d;
            core_start_q <= core_start_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            job_done_q   <= job_done_d;
            err_wrap_q   <= err_wrap_d;
        end
    end

    chacha20_out_buf u_out_buf (
        .clk          (clk),
        .reset        (reset),
        .load         (buf_load),
        .load_data    (core_keystream),
        .load_counter (counter_q),
        .load_last    (remaining_q == 1),
        .out_valid    (ks_valid),
        .out_ready    (ks_ready),
        .out_data     (ks_data),
        .out_counter  (ks_counter),
        .out_last     (ks_last)
    );

    assign cmd_ready    = cmd_ready_q;
    assign core_start   = core_start_q;
    assign core_key     = key_q;
    assign core_nonce   = nonce_q;
    assign core_counter = counter_q;
    assign busy         = busy_q;
    assign job_done     = job_done_q;
    assign err_wrap     = err_wrap_q;

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// tb/tb_chacha20_stream_ctrl.sv - self-checking bench for chacha20_stream_ctrl
module tb_chacha20_stream_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [255:0] cmd_key = '0;
    logic [95:0]  cmd_nonce = '0;
    logic [31:0]  cmd_counter = '0;
    logic [15:0]  cmd_nblocks = '0;
    logic         core_start;
    logic [255:0] core_key;
    logic [95:0]  core_nonce;
    logic [31:0]  core_counter;
    logic [511:0] core_keystream;
    logic         core_done;
    logic         ks_valid;
    logic         ks_ready = 1'b1;
    logic [511:0] ks_data;
    logic [31:0]  ks_counter;
    logic         ks_last;
    logic         busy, job_done, err_wrap;

    always #5 clk = ~clk;

    chacha20_stream_ctrl #(.MAX_BLOCKS_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_counter(cmd_counter), .cmd_nblocks(cmd_nblocks),
        .core_start(core_start), .core_key(core_key), .core_nonce(core_nonce), .core_counter(core_counter),
        .core_keystream(core_keystream), .core_done(core_done),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_counter(ks_counter), .ks_last(ks_last),
        .busy(busy), .job_done(job_done), .err_wrap(err_wrap)
    );

    localparam logic [255:0] RFC_KEY = {32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                        32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c};
    localparam logic [95:0]  RFC_NONCE = {32'h09000000, 32'h4a000000, 32'h00000000};
    localparam logic [511:0] RFC_BLOCK1 = {
        32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
        32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
        32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
        32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    function automatic logic [31:0] rotl(input logic [31:0] v, input int r);
        return (v << r) | (v >> (32 - r));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Reference ChaCha20 block: word 0 of the output sits in the top 32 bits
    function automatic logic [511:0] chacha(input logic [255:0] k, input logic [31:0] ctr, input logic [95:0] n);
        logic [31:0]  s[16];
        logic [31:0]  x[16];
        logic [511:0] r;
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[255-32*i -: 32];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13+i] = n[95-32*i -: 32];
        x = s;
        for (int i = 0; i < 10; i++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + s[i];
        return r;
    endfunction

    // Behavioural core: fixed latency after each rising core_start, plus injectable stray done pulses
    logic         cs_prev = 1'b0, c_busy = 1'b0, core_done_m = 1'b0, spur = 1'b0;
    logic [2:0]   c_cnt = '0;
    logic [511:0] c_data = '0, core_ks = '0;
    assign core_done      = core_done_m | spur;
    assign core_keystream = core_ks;

    always @(posedge clk) begin
        cs_prev     <= core_start;
        core_done_m <= 1'b0;
        if (core_start && !cs_prev && !c_busy) begin
            c_busy <= 1'b1;
            c_cnt  <= 3'd3;
            c_data <= chacha(core_key, core_counter, core_nonce);
        end else if (c_busy) begin
            if (c_cnt == 0) begin
                core_done_m <= 1'b1;
                core_ks     <= c_data;
                c_busy      <= 1'b0;
            end else begin
                c_cnt <= c_cnt - 1'b1;
            end
        end
    end

    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       ks_ready = 1'($urandom_range(0, 1));
            2:       ks_ready = 1'b0;
            default: ks_ready = 1'b1;
        endcase
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]  ctr;
        logic [511:0] data;
        logic         last;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   job_done_cnt = 0, job_done_cyc = -1, err_wrap_cnt = 0, err_wrap_cyc = -1;
    int   cs_rise_cnt = 0, delivered = 0;
    logic cs_mon_prev = 1'b0, ks_valid_seen = 1'b0;

    // Output monitor and scoreboard pop, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (job_done) begin job_done_cnt++; job_done_cyc = cyc; end
            if (err_wrap) begin err_wrap_cnt++; err_wrap_cyc = cyc; end
            if (ks_valid) ks_valid_seen = 1'b1;
            if (core_start && !cs_mon_prev) begin
                cs_rise_cnt++;
                check("start_with_buffer_full", ks_valid, 0);
            end
            if (ks_valid && ks_ready) begin
                exp_t e;
                delivered++;
                if (sb.size() == 0) begin
                    check("unexpected_block", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ks_counter", ks_counter, e.ctr);
                    check("ks_data", ks_data, e.data);
                    check("ks_last", ks_last, e.last);
                end
            end
        end
        cs_mon_prev = core_start;
    end

    assert property (@(posedge clk) disable iff (reset) (core_done && core_start) |=> !core_start)
        else begin n_fail++; $display("FAIL core_start_gap: core_start stayed high after core_done"); end

    task automatic start_job(input logic [31:0] ctr, input logic [15:0] nb, input int exp_n, output int acc_cyc);
        job_done_cnt = 0; err_wrap_cnt = 0; cs_rise_cnt = 0; delivered = 0;
        job_done_cyc = -1; err_wrap_cyc = -1;
        sb.delete();
        for (int i = 0; i < exp_n; i++) begin
            exp_t e;
            e.ctr  = ctr + 32'(i);
            e.data = chacha(RFC_KEY, e.ctr, RFC_NONCE);
            e.last = (i == exp_n - 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_key = RFC_KEY; cmd_nonce = RFC_NONCE;
        cmd_counter = ctr; cmd_nblocks = nb;
        @(posedge clk); #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, (nb != 0));
    endtask

    task automatic finish_job(input int acc_cyc, input logic [15:0] nb, input int exp_n, input logic exp_wrap);
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            if (job_done_cnt > 0) break;
        end
        repeat (2) @(posedge clk);
        #2;
        check("job_done_count", job_done_cnt, 1);
        if (nb == 0) check("job_done_latency", job_done_cyc, acc_cyc);
        check("err_wrap_count", err_wrap_cnt, exp_wrap);
        if (exp_wrap) check("err_wrap_on_accept", err_wrap_cyc, acc_cyc);
        check("blocks_delivered", delivered, exp_n);
        check("core_start_count", cs_rise_cnt, exp_n);
        check("scoreboard_empty", sb.size(), 0);
        check("busy_end", busy, 0);
        check("cmd_ready_end", cmd_ready, 1);
    endtask

    typedef struct {
        logic [31:0] ctr;
        logic [15:0] nb;
        int          exp_n;
        logic        exp_wrap;
        int          mode;
    } job_t;

    initial begin
        job_t         jobs[7];
        int           acc;
        logic [511:0] snap_d;
        logic [31:0]  snap_c;
        logic         snap_l;
        logic         stable;

        jobs[0] = '{32'd5,        16'd3, 3, 1'b0, 0};
        jobs[1] = '{32'd0,        16'd0, 0, 1'b0, 0};
        jobs[2] = '{32'hFFFFFFFE, 16'd4, 2, 1'b1, 0};
        jobs[3] = '{32'd1,        16'd1, 1, 1'b0, 0};
        jobs[4] = '{32'hFFFFFFFF, 16'd2, 1, 1'b1, 1};
        jobs[5] = '{32'd7,        16'd5, 5, 1'b0, 1};
        jobs[6] = '{32'hFFFFFFFD, 16'd3, 3, 1'b0, 1};

        check("rfc8439_model", chacha(RFC_KEY, 32'd1, RFC_NONCE), RFC_BLOCK1);

        repeat (3) @(posedge clk);
        #2;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_core_start", core_start, 0);
        check("rst_ks_valid", ks_valid, 0);
        check("rst_ks_last", ks_last, 0);
        check("rst_busy", busy, 0);
        check("rst_job_done", job_done, 0);
        check("rst_err_wrap", err_wrap, 0);
        check("rst_ks_counter", ks_counter, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int j = 0; j < 7; j++) begin
            rdy_mode = jobs[j].mode;
            start_job(jobs[j].ctr, jobs[j].nb, jobs[j].exp_n, acc);
            finish_job(acc, jobs[j].nb, jobs[j].exp_n, jobs[j].exp_wrap);
        end

        // Consumer stalls 20 cycles on the first block, with a stray core_done during the stall
        rdy_mode = 2;
        start_job(32'd10, 16'd2, 2, acc);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #2;
            if (ks_valid) break;
        end
        snap_d = ks_data; snap_c = ks_counter; snap_l = ks_last;
        stable = ks_valid;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            spur = (k == 5);
            if (!ks_valid || ks_data !== snap_d || ks_counter !== snap_c || ks_last !== snap_l) stable = 1'b0;
        end
        spur = 1'b0;
        check("stall_outputs_stable", stable, 1);
        check("stall_no_second_start", cs_rise_cnt, 1);
        rdy_mode = 0;
        finish_job(acc, 16'd2, 2, 1'b0);

        // Reset while the core works on block 2 of 4; its late done must be ignored
        rdy_mode = 0;
        start_job(32'd20, 16'd4, 4, acc);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (cs_rise_cnt >= 2) break;
        end
        @(posedge clk); #1;
        check("pre_reset_delivered", delivered, 1);
        reset = 1'b1;
        @(posedge clk); #2;
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_core_start", core_start, 0);
        check("mid_rst_ks_valid", ks_valid, 0);
        check("mid_rst_ks_last", ks_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_job_done", job_done, 0);
        check("mid_rst_ks_data", ks_data, 0);
        check("mid_rst_core_counter", core_counter, 0);
        sb.delete();
        job_done_cnt = 0; delivered = 0; cs_rise_cnt = 0; ks_valid_seen = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            spur = (k == 6);
        end
        spur = 1'b0;
        #1;
        check("post_rst_no_valid", ks_valid_seen, 0);
        check("post_rst_no_job_done", job_done_cnt, 0);
        check("post_rst_no_start", cs_rise_cnt, 0);
        check("post_rst_busy", busy, 0);

        start_job(32'd3, 16'd2, 2, acc);
        finish_job(acc, 16'd2, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
